// File: rtl/sseg_scan_mux.sv
// Four-digit seven-segment scan driver with frame-synchronous
// pattern capture, PWM dimming, per-digit blanking and a frame tick.
module sseg_scan_mux #(
  parameter int N     = 18,
  parameter int DIM_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       in0,
  input  logic [7:0]       in1,
  input  logic [7:0]       in2,
  input  logic [7:0]       in3,
  input  logic [DIM_W-1:0] bright,
  input  logic [3:0]       blank_mask,
  output logic [3:0]       an,
  output logic [7:0]       sseg,
  output logic [1:0]       digit_sel,
  output logic             frame_tick
);

  logic [N-1:0]       q_q, q_d;
  logic [3:0][7:0]    sh_q, sh_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic [1:0]         digit_sel_q, digit_sel_d;
  logic               frame_tick_q, frame_tick_d;

  logic [1:0]         d;
  logic [DIM_W-1:0]   p;
  logic               lit;

  assign d   = q_q[N-1 -: 2];
  assign p   = q_q[N-3 -: DIM_W];
  assign lit = (p <= bright) && !blank_mask[d];

  // Next counter, shadow capture on the last frame cycle, next outputs.
  // an and sseg come from the same q so they can never disagree on digit.
  always_comb begin
    q_d          = q_q + N'(1);
    sh_d         = sh_q;
    an_d         = 4'b1111;
    sseg_d       = 8'hFF;
    digit_sel_d  = d;
    frame_tick_d = (q_q == '0);
    if (&q_q) begin
      sh_d = {in3, in2, in1, in0};
    end
    if (lit) begin
      an_d   = ~(4'b0001 << d);
      sseg_d = sh_q[d];
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q          <= '0;
      sh_q         <= {4{8'hFF}};
      an_q         <= 4'b1111;
      sseg_q       <= 8'hFF;
      digit_sel_q  <= 2'd0;
      frame_tick_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      sh_q         <= sh_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign digit_sel  = digit_sel_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomized bench for sseg_scan_mux (N=6, DIM_W=2) against a
// frame/slot arithmetic reference model.
module tb_sseg_scan_mux;

  logic       clk;
  logic       reset_n;
  logic [7:0] in0, in1, in2, in3;
  logic [1:0] bright;
  logic [3:0] blank_mask;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [1:0] digit_sel;
  logic       frame_tick;

  int checks = 0;
  int failures = 0;

  int         mq;
  logic [7:0] msh [4];
  logic [3:0] e_an;
  logic [7:0] e_sseg;
  logic [1:0] e_dsel;
  logic       e_tick;

  sseg_scan_mux #(.N(6), .DIM_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .bright     (bright),
    .blank_mask (blank_mask),
    .an         (an),
    .sseg       (sseg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mq = 0;
    for (int i = 0; i < 4; i++) msh[i] = 8'hFF;
  endtask

  // One clock: predict from frame position, advance model, compare.
  task automatic step();
    int dg, ph;
    bit on;
    @(posedge clk);
    dg = mq / 16;
    ph = (mq % 16) / 4;
    on = (ph <= int'(bright)) && !blank_mask[dg];
    e_an   = on ? ~(4'b0001 << dg) : 4'b1111;
    e_sseg = on ? msh[dg] : 8'hFF;
    e_dsel = 2'(dg);
    e_tick = (mq == 0);
    if (mq == 63) begin
      msh[0] = in0; msh[1] = in1; msh[2] = in2; msh[3] = in3;
    end
    mq = (mq + 1) % 64;
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("sseg", 32'(sseg), 32'(e_sseg));
    chk("digit_sel", 32'(digit_sel), 32'(e_dsel));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0;
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
    bright = 2'd3;
    blank_mask = 4'b0000;
    model_reset();
    #23;
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_sseg", 32'(sseg), 32'h0000_00FF);
    chk("rst_dsel", 32'(digit_sel), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 0 keeps reset shadows; new patterns captured at its end.
    step();
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    run(63);
    run(64);

    // Dimming.
    bright = 2'd1;
    run(64);
    bright = 2'd0;
    run(64);

    // Blank digit 2 at full brightness.
    bright = 2'd3;
    blank_mask = 4'b0100;
    run(64);
    blank_mask = 4'b0000;

    // Mid-frame update at q=20 and again at q=63.
    while (mq != 20) step();
    in1 = 8'h99;
    while (mq != 63) step();
    in1 = 8'h92;
    run(128);

    // Random live inputs.
    for (int i = 0; i < 64 * 8; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        in0 = 8'($urandom); in1 = 8'($urandom);
        in2 = 8'($urandom); in3 = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 31) == 0) blank_mask = 4'($urandom);
      step();
    end

    // Asynchronous reset mid-frame.
    blank_mask = 4'b0000;
    bright = 2'd3;
    while (mq != 37) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'h0000_000F);
    chk("arst_sseg", 32'(sseg), 32'h0000_00FF);
    chk("arst_dsel", 32'(digit_sel), 32'h0);
    chk("arst_tick", 32'(frame_tick), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    run(64 * 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
